simple_single_cpu: RTL and testbench
====================================

# simple_single_cpu

Single-cycle 32-bit MIPS-subset processor. It executes one instruction per clock from an internal, bench-loadable instruction memory into a 32×32 register file. It has no data memory and no external data ports; its architectural state is observed hierarchically through the register file. It is the top of the Lab2 CPU datapath.

## Interface
- No parameters.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- No other ports.
- Backdoor names (fixed, the bench relies on them):
  - instance `IM` with array `Instr_Mem[0:31]` of 32-bit words, loaded by `$readmemb`.
  - instance `RF` with array `Reg_File[0:31]` of 32-bit words.

## Operation
- Fetch: `instr = IM.Instr_Mem[pc[6:2]]`. The PC is byte-addressed and word-aligned; the index wraps modulo 32 words.
- Decode fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- R-type (op=0x00) writes rd:
  - add 0x20: rs+rt
  - sub 0x22: rs−rt
  - and 0x24: rs&rt
  - or 0x25: rs|rt
  - slt 0x2A: signed rs<rt → 1, else 0
- Any other funct performs no write. This makes the all-zero word a NOP.
- I-type writes rt:
  - addi 0x08: rs+sext(imm)
  - slti 0x0A: signed rs<sext(imm)
  - sltiu 0x0B: unsigned rs<sext(imm) → 1/0 (immediate sign-extended, then compared unsigned)
  - ori 0x0D: rs|zext(imm)
  - lui 0x0F: {imm,16'h0}
- Branches (no register write):
  - beq 0x04: taken if rs==rt.
  - bne 0x05: taken if rs!=rt.
  - Target = pc+4+(sext(imm)<<2).
- Next PC = branch target if taken, else pc+4. No delay slot.
- Unknown opcodes: no write, pc+4.
- Arithmetic is 32-bit modulo; overflow is ignored (no trap).
- Register 0 always reads 0; writes to it are discarded.
- Two read ports are combinational. There is one synchronous write port.

## Timing
- Reset (rst_i=1 at a rising edge): pc←0 and Reg_File[0..31]←0. Instr_Mem is not cleared. Reset takes priority over any write in the same cycle.
- Mid-run reset aborts the current instruction with no write. Execution restarts at word 0 on the first edge with rst_i=0.
- Each non-reset rising edge retires exactly one instruction: the register write and PC update are both committed at that edge.
- Latency: a result written at edge N is visible to the instruction executed in cycle N+1 (read after write through the register file, no hazards).
- Branch decision and target are combinational within the same cycle.
- PC wrap: pc+4 from 0x7C fetches word 0 (index wrap); the full 32-bit pc still increments.

## Structure
- Shared package `simple_cpu_pkg` holds:
  - opcode and funct localparams listed above;
  - the ALU-control enum (ADD, SUB, AND, OR, SLT, SLTU, LUI);
  - word width (32).
- Sub-modules:
  - `instr_memory` (instance `IM`, array `Instr_Mem`)
  - `reg_file` (instance `RF`, array `Reg_File`, reset clearing, r0 hardwiring)
- Decoder, ALU, sign/zero extension, and PC logic live in the top level or in a small `alu` sub-module.

## Test plan
- **Reset:** hold rst_i=1 for 2 edges → pc=0 and r1..r31=0. Release → the word-0 instruction retires on the next edge.
- **ALU ops:** `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `sub $4,$1,$2`; `and/or $5,$6` → r1=5, r2=0xFFFFFFFD, r3=2, r4=8, r5=5&r2=5, r6=0xFFFFFFFD.
- **sltiu:** with r1=5:
  - `sltiu $7,$1,-1` → r7=1 (5 <u 0xFFFFFFFF).
  - `sltiu $8,$2,10` → r8=0.
  - `sltiu $9,$1,6` → r9=1.
  - `slti $10,$2,0` → r10=1.
- **Branch:** `beq $1,$1,+1` skips the next `addi $11,$0,7` → r11=0. `bne $1,$1,+1` not taken → fall-through executes.
- **r0 and immediates:** `addi $0,$0,9` → r0 stays 0. `lui $12,0x1234`; `ori $12,$12,0x8000` → r12=0x12348000 (ori zero-extends).
- **Mid-run reset:** assert rst_i during a program → all registers 0 at that edge, pc=0. The program reruns and yields identical final values.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset CPU: opcodes, functs,
// ALU control encoding and word width.
package simple_cpu_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned NumRegs = 32;

  // Primary opcodes
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt,
    AluSltu,
    AluLui
  } alu_op_e;

  function automatic logic [WordWidth-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/simple_single_cpu_if.sv
// Register-file access bundle: two combinational read ports, one write port.
interface simple_single_cpu_if;
  import simple_cpu_pkg::*;

  logic [RegAddrWidth-1:0] rs_addr;
  logic [RegAddrWidth-1:0] rt_addr;
  logic [WordWidth-1:0]    rs_data;
  logic [WordWidth-1:0]    rt_data;
  logic                    wr_en;
  logic [RegAddrWidth-1:0] wr_addr;
  logic [WordWidth-1:0]    wr_data;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output rs_data, rt_data
  );

endinterface

// File: rtl/instr_memory.sv
// 32-word instruction ROM, contents loaded from outside the design.
module instr_memory
  import simple_cpu_pkg::*;
(
  input  logic [4:0]           addr,
  output logic [WordWidth-1:0] instr
);

  logic [WordWidth-1:0] Instr_Mem [0:31];

  // Asynchronous read
  always_comb begin
    instr = Instr_Mem[addr];
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file; r0 reads as zero and ignores writes, reset clears all.
module reg_file
  import simple_cpu_pkg::*;
(
  input logic                clk,
  input logic                rst,
  simple_single_cpu_if.slave bus
);

  logic [WordWidth-1:0] Reg_File [0:NumRegs-1];

  // Combinational reads with r0 forced to zero
  always_comb begin
    bus.rs_data = (bus.rs_addr == '0) ? '0 : Reg_File[bus.rs_addr];
    bus.rt_data = (bus.rt_addr == '0) ? '0 : Reg_File[bus.rt_addr];
  end

  // Synchronous write; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        Reg_File[i] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      Reg_File[bus.wr_addr] <= bus.wr_data;
    end
  end

endmodule

// File: rtl/simple_single_cpu.sv
// Single-cycle MIPS-subset CPU: fetch, decode, ALU, branch and PC update.
module simple_single_cpu
  import simple_cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i
);

  logic [WordWidth-1:0] pc_q, pc_d;
  logic [WordWidth-1:0] instr;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  alu_op_e              alu_op;
  logic                 use_imm, imm_zext, wr_en, wr_rt, is_beq, is_bne;
  logic [WordWidth-1:0] imm_sext, imm_zx, alu_b, alu_y;
  logic [WordWidth-1:0] pc_plus4, br_target;
  logic                 taken;
  logic                 unused_shamt;

  simple_single_cpu_if rf_bus ();

  instr_memory IM (
    .addr  (pc_q[6:2]),
    .instr (instr)
  );

  reg_file RF (
    .clk (clk_i),
    .rst (rst_i),
    .bus (rf_bus)
  );

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = sext16(imm);
  assign imm_zx   = {16'h0000, imm};
  assign unused_shamt = ^instr[10:6];

  // Decode opcode/funct into ALU control, operand select and write enable
  always_comb begin
    alu_op   = AluAdd;
    use_imm  = 1'b0;
    imm_zext = 1'b0;
    wr_en    = 1'b0;
    wr_rt    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (op)
      OpRType: begin
        wr_en = 1'b1;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnSlt:   alu_op = AluSlt;
          default: wr_en  = 1'b0;  // unsupported funct (incl. all-zero NOP)
        endcase
      end
      OpAddi: begin
        alu_op = AluAdd; use_imm = 1'b1; wr_en = 1'b1; wr_rt = 1'b1;
      end
      OpSlti: begin
        alu_op = AluSlt; use_imm = 1'b1; wr_en = 1'b1; wr_rt = 1'b1;
      end
      OpSltiu: begin
        alu_op = AluSltu; use_imm = 1'b1; wr_en = 1'b1; wr_rt = 1'b1;
      end
      OpOri: begin
        alu_op = AluOr; use_imm = 1'b1; imm_zext = 1'b1; wr_en = 1'b1; wr_rt = 1'b1;
      end
      OpLui: begin
        alu_op = AluLui; use_imm = 1'b1; imm_zext = 1'b1; wr_en = 1'b1; wr_rt = 1'b1;
      end
      OpBeq:   is_beq = 1'b1;
      OpBne:   is_bne = 1'b1;
      default: ;
    endcase
  end

  // ALU; sltiu compares against the sign-extended immediate as unsigned
  always_comb begin
    alu_b = use_imm ? (imm_zext ? imm_zx : imm_sext) : rf_bus.rt_data;
    case (alu_op)
      AluAdd:  alu_y = rf_bus.rs_data + alu_b;
      AluSub:  alu_y = rf_bus.rs_data - alu_b;
      AluAnd:  alu_y = rf_bus.rs_data & alu_b;
      AluOr:   alu_y = rf_bus.rs_data | alu_b;
      AluSlt:  alu_y = {31'b0, ($signed(rf_bus.rs_data) < $signed(alu_b))};
      AluSltu: alu_y = {31'b0, (rf_bus.rs_data < alu_b)};
      AluLui:  alu_y = {alu_b[15:0], 16'h0000};
      default: alu_y = '0;
    endcase
  end

  // Register-file port drive
  always_comb begin
    rf_bus.rs_addr = rs;
    rf_bus.rt_addr = rt;
    rf_bus.wr_en   = wr_en;
    rf_bus.wr_addr = wr_rt ? rt : rd;
    rf_bus.wr_data = alu_y;
  end

  // Branch resolution and next PC
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    taken     = (is_beq && (rf_bus.rs_data == rf_bus.rt_data)) ||
                (is_bne && (rf_bus.rs_data != rf_bus.rt_data));
    pc_d      = taken ? br_target : pc_plus4;
  end

  // PC register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_simple_single_cpu.sv
// Directed bench for simple_single_cpu: program table with per-word final
// register expectations plus hand-written reset/branch/timing sequences.
module tb_simple_single_cpu;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] instr;
    int          chk_reg;
    logic [31:0] chk_val;
  } row_t;

  localparam int NRows = 24;
  row_t tbl [NRows];

  simple_single_cpu dut (
    .clk_i (clk),
    .rst_i (rst)
  );

  // Tap of the DUT's register-file write port
  simple_single_cpu_if mon_if ();
  assign mon_if.wr_en = dut.rf_bus.wr_en;

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pc"}, dut.pc_q, 32'h0);
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("%s r%0d", tag, r), dut.RF.Reg_File[r], 32'h0);
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < NRows; i++) begin
      chk($sformatf("%s row%0d r%0d", tag, i, tbl[i].chk_reg),
          dut.RF.Reg_File[tbl[i].chk_reg], tbl[i].chk_val);
    end
  endtask

  initial begin
    rst = 1'b1;

    // word: instruction, register to check at the end, expected final value
    tbl[0]  = '{i_type(6'h08, 5'd0, 5'd1, 16'd5),     1,  32'd5};
    tbl[1]  = '{i_type(6'h08, 5'd0, 5'd2, 16'hFFFD),  2,  32'hFFFF_FFFD};
    tbl[2]  = '{r_type(5'd1, 5'd2, 5'd3, 6'h20),      3,  32'd2};
    tbl[3]  = '{r_type(5'd1, 5'd2, 5'd4, 6'h22),      4,  32'd8};
    tbl[4]  = '{r_type(5'd1, 5'd2, 5'd5, 6'h24),      5,  32'd5};
    tbl[5]  = '{r_type(5'd1, 5'd2, 5'd6, 6'h25),      6,  32'hFFFF_FFFD};
    tbl[6]  = '{i_type(6'h0B, 5'd1, 5'd7, 16'hFFFF),  7,  32'd1};
    tbl[7]  = '{i_type(6'h0B, 5'd2, 5'd8, 16'd10),    8,  32'd0};
    tbl[8]  = '{i_type(6'h0B, 5'd1, 5'd9, 16'd6),     9,  32'd1};
    tbl[9]  = '{i_type(6'h0A, 5'd2, 5'd10, 16'd0),    10, 32'd1};
    tbl[10] = '{i_type(6'h04, 5'd1, 5'd1, 16'd1),     0,  32'd0};
    tbl[11] = '{i_type(6'h08, 5'd0, 5'd11, 16'd7),    11, 32'd0};   // skipped
    tbl[12] = '{i_type(6'h05, 5'd1, 5'd1, 16'd1),     0,  32'd0};
    tbl[13] = '{i_type(6'h08, 5'd0, 5'd13, 16'd7),    13, 32'd7};
    tbl[14] = '{i_type(6'h08, 5'd0, 5'd0, 16'd9),     0,  32'd0};
    tbl[15] = '{i_type(6'h0F, 5'd0, 5'd12, 16'h1234), 12, 32'h1234_8000};
    tbl[16] = '{i_type(6'h0D, 5'd12, 5'd12, 16'h8000), 12, 32'h1234_8000};
    tbl[17] = '{r_type(5'd2, 5'd1, 5'd14, 6'h2A),     14, 32'd1};
    tbl[18] = '{r_type(5'd1, 5'd2, 5'd15, 6'h2A),     15, 32'd0};
    tbl[19] = '{i_type(6'h3F, 5'd1, 5'd20, 16'h0055), 20, 32'd0};   // unknown op
    tbl[20] = '{r_type(5'd1, 5'd2, 5'd21, 6'h27),     21, 32'd0};   // unsupported funct
    tbl[21] = '{i_type(6'h0F, 5'd0, 5'd16, 16'h8000), 16, 32'h8000_0000};
    tbl[22] = '{i_type(6'h08, 5'd16, 5'd18, 16'hFFFF), 18, 32'h7FFF_FFFF};
    tbl[23] = '{i_type(6'h04, 5'd0, 5'd0, 16'hFFFF),  0,  32'd0};   // spin here

    for (int i = 0; i < 32; i++) begin
      dut.IM.Instr_Mem[i] = (i < NRows) ? tbl[i].instr : 32'h0;
    end

    // Reset held for two edges
    step(2);
    check_all_zero("reset");

    // First edge after release retires word 0
    rst = 1'b0;
    #1;
    chk("wr_en addi", {31'b0, mon_if.wr_en}, 32'd1);
    step(1);
    chk("pc after 1", dut.pc_q, 32'd4);
    chk("r1 after 1", dut.RF.Reg_File[1], 32'd5);
    chk("r2 after 1", dut.RF.Reg_File[2], 32'd0);

    // Back-to-back read-after-write
    step(2);
    chk("pc after 3", dut.pc_q, 32'd12);
    chk("r3 raw", dut.RF.Reg_File[3], 32'd2);

    // Taken beq at word 10 skips word 11
    step(8);
    chk("pc after beq", dut.pc_q, 32'h30);
    step(1);
    chk("pc after bne", dut.pc_q, 32'h34);

    // Unknown opcode and unsupported funct must not write
    step(6);
    chk("pc at word 19", dut.pc_q, 32'h4C);
    chk("wr_en unknown op", {31'b0, mon_if.wr_en}, 32'd0);
    step(1);
    chk("wr_en bad funct", {31'b0, mon_if.wr_en}, 32'd0);

    // Reach the self-loop and check final state
    step(30);
    chk("pc spin", dut.pc_q, 32'h5C);
    check_table("run1");

    // Mid-run reset during a register-writing instruction (word 8)
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    chk("pc before midreset", dut.pc_q, 32'h20);
    rst = 1'b1;
    step(1);
    check_all_zero("midreset");
    rst = 1'b0;
    step(40);
    chk("pc spin rerun", dut.pc_q, 32'h5C);
    check_table("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
